// File: rtl/usb_turnaround_ctrl.sv
// USB 2.0 link-layer half-duplex turnaround and response-timeout controller.
// Optional tx_cancel abort is built when TURNAROUND_CANCEL_EN is defined.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ms                 1 = master, 0 = slave
//   time_threshold     response timeout in cycles (0 = wait forever)
//   delay_threshole    inter-packet gap in cycles
//   tx_req/tx_done     TX engine request / final byte accepted
//   expect_resp        with tx_done: a reply is expected
//   rx_sop/rx_eop      RX packet start / end accepted
//   tx_cancel          abort TX (TURNAROUND_CANCEL_EN only)
//   tx_grant, d_oe     TX may transmit / drive bus
//   rx_en              RX path may accept data
//   time_out           one-cycle pulse on response timeout
//   busy               not idle, or gap still running
`timescale 1ns/1ps

module usb_turnaround_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms,
    input  logic [15:0] time_threshold,
    input  logic [5:0]  delay_threshole,
    input  logic        tx_req,
    input  logic        tx_done,
    input  logic        expect_resp,
    input  logic        rx_sop,
    input  logic        rx_eop,
`ifdef TURNAROUND_CANCEL_EN
    input  logic        tx_cancel,
`endif
    output logic        tx_grant,
    output logic        d_oe,
    output logic        rx_en,
    output logic        time_out,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RX   = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_nx;
    logic [5:0]  gap_cnt;
    logic [5:0]  gap_nx;
    logic [15:0] to_cnt;
    logic        resp_pend;
    logic        rx_short;
    logic        cancel_hit;
    logic        tx_ok;
    logic        to_hit;

`ifdef TURNAROUND_CANCEL_EN
    assign cancel_hit = (state_q == S_TX) && tx_cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    // Slaves may only answer a received packet.
    assign tx_ok = (gap_cnt == 6'd0) && (ms || resp_pend);

    // rx_sop on the expiry cycle takes the reply instead.
    assign to_hit = (state_q == S_WAIT)
                 && (time_threshold != 16'd0)
                 && (to_cnt == time_threshold - 16'd1)
                 && !rx_sop;

    assign time_out = to_hit;

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_sop)
                    state_nx = S_RX;
                else if (tx_req && tx_ok)
                    state_nx = S_TX;
            end
            S_TX: begin
                if (cancel_hit)
                    state_nx = S_IDLE;
                else if (tx_done)
                    state_nx = expect_resp ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (rx_sop)
                    state_nx = S_RX;
                else if (to_hit)
                    state_nx = S_IDLE;
            end
            S_RX: begin
                // rx_short: the 1-byte packet's eop came with its sop.
                if (rx_eop || rx_short)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        gap_nx = gap_cnt;
        if (tx_done || rx_eop || to_hit || cancel_hit)
            gap_nx = delay_threshole;
        else if (gap_cnt != 6'd0)
            gap_nx = gap_cnt - 6'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gap_cnt   <= 6'd0;
            to_cnt    <= 16'd0;
            resp_pend <= 1'b0;
            rx_short  <= 1'b0;
            tx_grant  <= 1'b0;
            d_oe      <= 1'b0;
            rx_en     <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q <= state_nx;
            gap_cnt <= gap_nx;

            if (state_nx == S_WAIT && state_q != S_WAIT)
                to_cnt <= 16'd0;
            else if (state_q == S_WAIT && to_cnt != 16'hFFFF)
                to_cnt <= to_cnt + 16'd1;

            if (state_nx == S_TX && state_q != S_TX)
                resp_pend <= 1'b0;
            else if (rx_eop)
                resp_pend <= 1'b1;

            rx_short <= (state_nx == S_RX) && (state_q != S_RX) && rx_eop;

            tx_grant <= (state_nx == S_TX);
            d_oe     <= (state_nx == S_TX);
            rx_en    <= (state_nx != S_TX);
            busy     <= (state_nx != S_IDLE) || (gap_nx != 6'd0);
        end
    end

endmodule

// File: tb/tb_usb_turnaround_ctrl.sv
// Directed self-checking bench for usb_turnaround_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there.
`timescale 1ns/1ps

module tb_usb_turnaround_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ms = 1'b1;
    logic [15:0] time_threshold = 16'd0;
    logic [5:0]  delay_threshole = 6'd0;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        expect_resp = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
`ifdef TURNAROUND_CANCEL_EN
    logic        tx_cancel = 1'b0;
`endif
    logic        tx_grant;
    logic        d_oe;
    logic        rx_en;
    logic        time_out;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    usb_turnaround_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ms              (ms),
        .time_threshold  (time_threshold),
        .delay_threshole (delay_threshole),
        .tx_req          (tx_req),
        .tx_done         (tx_done),
        .expect_resp     (expect_resp),
        .rx_sop          (rx_sop),
        .rx_eop          (rx_eop),
`ifdef TURNAROUND_CANCEL_EN
        .tx_cancel       (tx_cancel),
`endif
        .tx_grant        (tx_grant),
        .d_oe            (d_oe),
        .rx_en           (rx_en),
        .time_out        (time_out),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int found;

        // reset
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk1("rst_d_oe", d_oe, 1'b0);
        chk1("rst_grant", tx_grant, 1'b0);
        chk1("rst_rx_en", rx_en, 1'b1);
        chk1("rst_time_out", time_out, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // master grant
        tx_req = 1'b1;
        tick();
        chk1("m_grant", tx_grant, 1'b1);
        chk1("m_d_oe", d_oe, 1'b1);
        chk1("m_rx_en", rx_en, 1'b0);
        chk1("m_busy", busy, 1'b1);
        tick();
        tick();
        tick();
        chk1("m_grant_held", tx_grant, 1'b1);
        tx_done = 1'b1;
        tx_req = 1'b0;
        tick();
        tx_done = 1'b0;
        chk1("m_done_d_oe", d_oe, 1'b0);
        chk1("m_done_grant", tx_grant, 1'b0);
        chk1("m_done_rx_en", rx_en, 1'b1);
        chk1("m_done_busy", busy, 1'b0);

        // gap enforcement, delay 4
        delay_threshole = 6'd4;
        tx_req = 1'b1;
        tick();
        chk1("gap_first_grant", tx_grant, 1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk1("gap_n1_d_oe", d_oe, 1'b0);
        chk1("gap_n1_busy", busy, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_grant) cnt_a++;
            if (!busy) cnt_b++;
        end
        chkn("gap_no_grant", cnt_a, 0);
        chkn("gap_busy_low", cnt_b, 0);
        tick();
        chk1("gap_n5_grant", tx_grant, 1'b0);
        tick();
        chk1("gap_n6_grant", tx_grant, 1'b1);

        // timeout, threshold 8
        delay_threshole = 6'd0;
        time_threshold = 16'd8;
        tx_req = 1'b0;
        tx_done = 1'b1;
        expect_resp = 1'b1;
        tick();
        tx_done = 1'b0;
        expect_resp = 1'b0;
        cnt_a = time_out ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (time_out) cnt_a++;
        end
        chkn("to_early", cnt_a, 0);
        tick();
        chk1("to_pulse", time_out, 1'b1);
        chk1("to_pulse_busy", busy, 1'b1);
        tick();
        chk1("to_after", time_out, 1'b0);
        chk1("to_idle_busy", busy, 1'b0);
        chk1("to_idle_rx_en", rx_en, 1'b1);

        // reply at wait cycle 3
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tx_done = 1'b1;
        expect_resp = 1'b1;
        tick();
        tx_done = 1'b0;
        expect_resp = 1'b0;
        tick();
        rx_sop = 1'b1;
        tick();
        rx_sop = 1'b0;
        chk1("resp_rx_en", rx_en, 1'b1);
        chk1("resp_d_oe", d_oe, 1'b0);
        chk1("resp_busy", busy, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (time_out) cnt_a++;
            if (!busy) cnt_b++;
        end
        chkn("resp_no_to", cnt_a, 0);
        chkn("resp_stay_rx", cnt_b, 0);
        delay_threshole = 6'd3;
        rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
        chk1("resp_gap_busy", busy, 1'b1);
        tick();
        tick();
        tick();
        chk1("resp_gap_done", busy, 1'b0);

        // rx_sop on the expiry cycle
        delay_threshole = 6'd0;
        time_threshold = 16'd4;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tx_done = 1'b1;
        expect_resp = 1'b1;
        tick();
        tx_done = 1'b0;
        expect_resp = 1'b0;
        tick();
        tick();
        tick();
        chk1("col_armed", time_out, 1'b1);
        rx_sop = 1'b1;
        #1;
        chk1("col_suppressed", time_out, 1'b0);
        tick();
        rx_sop = 1'b0;
        chk1("col_rx_busy", busy, 1'b1);
        chk1("col_rx_to", time_out, 1'b0);
        rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
        chk1("col_idle", busy, 1'b0);

        // threshold 0 never times out
        time_threshold = 16'd0;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tx_done = 1'b1;
        expect_resp = 1'b1;
        tick();
        tx_done = 1'b0;
        expect_resp = 1'b0;
        cnt_a = 0;
        repeat (70000) begin
            tick();
            if (time_out) cnt_a++;
        end
        chkn("inf_no_to", cnt_a, 0);
        chk1("inf_busy", busy, 1'b1);
        rx_sop = 1'b1;
        rx_eop = 1'b1;
        tick();
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        chk1("short_rx_busy", busy, 1'b1);
        chk1("short_rx_en", rx_en, 1'b1);
        tick();
        chk1("short_idle", busy, 1'b0);

        // rx_sop beats tx_req in idle
        tx_req = 1'b1;
        rx_sop = 1'b1;
        tick();
        rx_sop = 1'b0;
        chk1("prio_no_grant", tx_grant, 1'b0);
        chk1("prio_rx_busy", busy, 1'b1);
        rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
        chk1("prio_idle_grant", tx_grant, 1'b0);
        tick();
        chk1("prio_pending_grant", tx_grant, 1'b1);

        // async reset during TX
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk1("arst_d_oe", d_oe, 1'b0);
        chk1("arst_grant", tx_grant, 1'b0);
        chk1("arst_rx_en", rx_en, 1'b1);
        chk1("arst_busy", busy, 1'b0);
        tx_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // slave initiation rule
        ms = 1'b0;
        delay_threshole = 6'd2;
        tx_req = 1'b1;
        cnt_a = 0;
        repeat (100) begin
            tick();
            if (tx_grant) cnt_a++;
        end
        chkn("slv_no_grant", cnt_a, 0);
        rx_sop = 1'b1;
        tick();
        rx_sop = 1'b0;
        rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
        chk1("slv_e1", tx_grant, 1'b0);
        tick();
        chk1("slv_e2", tx_grant, 1'b0);
        tick();
        chk1("slv_e3", tx_grant, 1'b0);
        tick();
        chk1("slv_e4_grant", tx_grant, 1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        cnt_a = 0;
        repeat (100) begin
            tick();
            if (tx_grant) cnt_a++;
        end
        chkn("slv_second_blocked", cnt_a, 0);
        rx_sop = 1'b1;
        rx_eop = 1'b1;
        tick();
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (found == 0) begin
                tick();
                if (tx_grant) found = 1;
            end
        end
        chkn("slv_rearmed_grant", found, 1);
        tx_req = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

`ifdef TURNAROUND_CANCEL_EN
        // cancel beats tx_done
        ms = 1'b1;
        delay_threshole = 6'd3;
        time_threshold = 16'd2;
        repeat (3) tick();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tick();
        tx_cancel = 1'b1;
        tx_done = 1'b1;
        expect_resp = 1'b1;
        tick();
        tx_cancel = 1'b0;
        tx_done = 1'b0;
        expect_resp = 1'b0;
        chk1("cxl_d_oe", d_oe, 1'b0);
        chk1("cxl_grant", tx_grant, 1'b0);
        chk1("cxl_busy", busy, 1'b1);
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (time_out) cnt_a++;
        end
        chkn("cxl_no_wait", cnt_a, 0);
        chk1("cxl_idle", busy, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_turnaround_ctrl.md
# usb_turnaround_ctrl

Half-duplex bus turnaround and response-timeout controller for the USB 2.0 link layer. It sits between the link-layer TX/RX packet engines and the PHY-side packet interface. It decides when the link may drive the bus (`d_oe`), when the TX engine may start a packet, how long to wait for a reply, and the inter-packet gap. It also enforces the master/slave initiation rule selected by `ms`.

## Interface
Parameters:
- none. Widths are fixed by the register interface: `time_threshold` is 16 bits, `delay_threshole` is 6 bits.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ms`  in  1  mode: 1 = master, 0 = slave. Quasi-static; sampled every cycle.
- `time_threshold`  in  16  response timeout, in cycles. 0 disables the timeout.
- `delay_threshole`  in  6  inter-packet gap, in cycles.
- `tx_req`  in  1  the TX engine has a packet ready (level signal).
- `tx_done`  in  1  final byte accepted at the PHY (`tx_lp_valid & tx_lp_ready & tx_lp_eop`).
- `expect_resp`  in  1  sampled together with `tx_done`: the sent packet expects a reply.
- `rx_sop`  in  1  start of packet accepted (`rx_lp_valid & rx_lp_ready & rx_lp_sop`).
- `rx_eop`  in  1  end of packet accepted (`rx_lp_valid & rx_lp_ready & rx_lp_eop`).
- `tx_cancel`  in  1  abort the current transmission. Present only with `TURNAROUND_CANCEL_EN`.
- `tx_grant`  out  1  the TX engine may transmit. Held until `tx_done`.
- `d_oe`  out  1  bus drive enable.
- `rx_en`  out  1  the RX path may accept PHY data.
- `time_out`  out  1  one-cycle pulse when the response wait expires.
- `busy`  out  1  the state machine is not in IDLE, or the gap counter is nonzero.

## Operation
- **States:** IDLE, TX, WAIT_RESP, RX. State is held in a 2-bit register.
- **IDLE**
  - `rx_sop` moves to RX, regardless of the gap counter or mode.
  - `tx_req` moves to TX if both hold:
    - `gap_cnt==0`;
    - `ms==1`, or `resp_pend==1`.
  - If `rx_sop` and an eligible `tx_req` occur in the same cycle, RX wins and `tx_req` stays pending.
- **TX:** `tx_done` moves to WAIT_RESP if `expect_resp==1`, otherwise to IDLE.
- **WAIT_RESP**
  - `rx_sop` moves to RX.
  - `to_cnt` counts up from 0. When `to_cnt==time_threshold-1` (and `time_threshold != 0`), pulse `time_out` and go to IDLE.
- **RX:** `rx_eop` moves to IDLE. `rx_sop` and `rx_eop` in the same cycle (a 1-byte packet) pass through RX for one cycle.
- **Gap counter (`gap_cnt`, 6 bits)**
  - Loads `delay_threshole` on `tx_done`, on `rx_eop`, and on timeout.
  - Otherwise decrements toward 0 and saturates at 0.
  - `delay_threshole==0` means no gap.
- **`resp_pend` flag (slave initiation rule)**
  - Set on `rx_eop`.
  - Cleared on entry to TX.
  - Effect: a slave only transmits in reply to a received packet. In master mode the flag is ignored.
- **Timeout counter (`to_cnt`, 16 bits):** cleared on entry to WAIT_RESP. It never wraps, because the timeout exits the state first; with `time_threshold==0` it saturates at 0xFFFF and WAIT_RESP waits indefinitely.
- **Outputs are registered and derived from the next state:**
  - `d_oe = tx_grant = (state==TX)`;
  - `rx_en = (state != TX)`.
- **Changing `ms` mid-transaction** does not affect the current state. It only affects the next IDLE→TX decision.

## Timing
- **Reset values:**
  - state IDLE;
  - `gap_cnt`=0, `to_cnt`=0, `resp_pend`=0;
  - `d_oe`=0, `tx_grant`=0, `time_out`=0, `busy`=0;
  - `rx_en`=1.
- **Reset asserted mid-packet:** all of the above take effect immediately, so `d_oe` drops asynchronously.
- **Grant latency:** eligible `tx_req` in cycle N → `tx_grant` and `d_oe` high in cycle N+1.
- **End of transmission:** `tx_done` in cycle N → `d_oe` low in cycle N+1, and `gap_cnt=delay_threshole` in N+1.
- **Minimum `tx_done`→next grant** with `tx_req` held: `delay_threshole`+1 cycles from N+1.
- **Timeout:** `time_out` is high exactly `time_threshold` cycles after the WAIT_RESP entry cycle (entry cycle counted as 1). It lasts one cycle, and state is IDLE in the following cycle.
- **`rx_sop` on the cycle the timeout would fire:** RX wins and no `time_out` pulse is generated.

## Configuration
- **`TURNAROUND_CANCEL_EN` defined:**
  - The `tx_cancel` port exists.
  - `tx_cancel` in TX → IDLE next cycle: `d_oe`/`tx_grant` go low, `gap_cnt` loads `delay_threshole`, `resp_pend` is not restored.
  - `tx_cancel` and `tx_done` in the same cycle: cancel wins.
- **Not defined:** the `tx_cancel` port is absent and TX exits only on `tx_done`.

## Test plan
- **Reset, then master grant:** `ms`=1, `delay_threshole`=0, raise `tx_req` at cycle 5 → `tx_grant`/`d_oe`=1 at cycle 6; `tx_done` with `expect_resp`=0 at cycle 10 → `d_oe`=0 at cycle 11.
- **Gap enforcement:** `delay_threshole`=4, `tx_done` at N with `tx_req` held → next `tx_grant` at N+6 (five cycles low), and `busy`=1 throughout.
- **Timeout:** `time_threshold`=8, `expect_resp`=1, no RX activity → `time_out` is a single pulse 8 cycles after WAIT_RESP entry, then IDLE; with `time_threshold`=0 and no RX for 70000 cycles, no pulse occurs.
- **Response and priority:** in WAIT_RESP, `rx_sop` at cycle 3 → RX and `rx_en`=1; `rx_eop` → IDLE with the gap loaded. In IDLE, simultaneous `rx_sop` and `tx_req` → RX.
- **Slave rule:** `ms`=0, `tx_req` held with no prior RX → no grant for 100 cycles; `rx_eop` then arrives → grant after the gap; a second `tx_req` after that TX gets no grant until another `rx_eop`.
- **Cancel (`TURNAROUND_CANCEL_EN`):** `tx_cancel` at TX cycle 2 → `d_oe`=0 next cycle and no WAIT_RESP; asynchronous `rst_n` pulse mid-TX → `d_oe`=0 immediately.
